// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and FSM state encoding for the demux dispatch controller
package demux_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;
    localparam int N_OUT  = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        STALL = 2'd2
    } state_e;

endpackage

// File: rtl/demux_rr_ptr.sv
// rtl/demux_rr_ptr.sv - wrapping round-robin lane pointer with advance enable
module demux_rr_ptr #(
    parameter int SEL_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_adv,
    output logic [SEL_W-1:0] o_ptr
);

    logic [SEL_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (i_adv) ptr_d = ptr_q + SEL_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - word hold/dispatch FSM with stall watchdog; DEMUX_DISPATCH_CNT_EN adds per-lane delivery counters
module demux_dispatch_ctrl #(
    parameter int DATA_W    = demux_pkg::DATA_W,
    parameter int SEL_W     = demux_pkg::SEL_W,
    parameter int STALL_LIM = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mode,
    input  logic [SEL_W-1:0]      i_dest,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_W-1:0]     i_in,
    output logic [DATA_W-1:0]     o_data,
    output logic [SEL_W-1:0]      o_sel,
    output logic [(1<<SEL_W)-1:0] o_valid,
    input  logic [(1<<SEL_W)-1:0] i_ready,
`ifdef DEMUX_DISPATCH_CNT_EN
    input  logic [SEL_W-1:0]      i_cnt_sel,
    output logic [15:0]           o_cnt,
`endif
    output logic                  o_stall,
    output logic                  o_busy
);

    import demux_pkg::*;

    localparam int         N_OUT = 1 << SEL_W;
    localparam logic [7:0] LIM   = 8'(STALL_LIM);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [N_OUT-1:0]    valid_q, valid_d;
    logic                stall_q, stall_d;
    logic                busy_q, busy_d;
    logic [7:0]          scnt_q, scnt_d;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    dest;
    logic                deliver, accept;

    // valid_q is zero in IDLE, so delivery can only happen while a word is held
    assign deliver = valid_q[sel_q] & i_ready[sel_q];
    assign o_ready = (state_q == IDLE) | deliver;
    assign accept  = i_valid & o_ready;
    assign dest    = i_mode ? i_dest : rr_ptr;

    demux_rr_ptr #(.SEL_W(SEL_W)) u_rr_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_adv (accept & ~i_mode),
        .o_ptr (rr_ptr)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        stall_d = stall_q;
        scnt_d  = scnt_q;
        if (accept) begin
            data_d  = i_in;
            sel_d   = dest;
            valid_d = {{(N_OUT-1){1'b0}}, 1'b1} << dest;
        end
        case (state_q)
            IDLE: if (accept) state_d = HOLD;
            HOLD, STALL: begin
                if (deliver) begin
                    scnt_d  = '0;
                    stall_d = 1'b0;
                    if (accept) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        valid_d = '0;
                    end
                end else begin
                    if (scnt_q != 8'hFF) scnt_d = scnt_q + 8'd1;
                    if (scnt_d >= LIM) begin
                        state_d = STALL;
                        stall_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= '0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
            scnt_q  <= scnt_d;
        end
    end

    assign o_data  = data_q;
    assign o_sel   = sel_q;
    assign o_valid = valid_q;
    assign o_stall = stall_q;
    assign o_busy  = busy_q;

`ifdef DEMUX_DISPATCH_CNT_EN
    logic [15:0] cnt_q [N_OUT];
    logic [15:0] cnt_d [N_OUT];

    always_comb begin
        for (int i = 0; i < N_OUT; i++) cnt_d[i] = cnt_q[i];
        if (deliver) cnt_d[sel_q] = cnt_q[sel_q] + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N_OUT; i++) begin
            if (i_rst) cnt_q[i] <= '0;
            else       cnt_q[i] <= cnt_d[i];
        end
    end

    assign o_cnt = cnt_q[i_cnt_sel];
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb/tb_demux_dispatch_ctrl.sv - self-checking bench: vector table, directed corner sequences, randomized model compare
module tb_demux_dispatch_ctrl;

    localparam int LIM = 15;

    logic        i_clk = 1'b0;
    logic        i_rst, i_mode, i_valid;
    logic [2:0]  i_dest, i_cnt_sel;
    logic [15:0] i_in, o_data;
    logic [7:0]  i_ready, o_valid;
    logic [2:0]  o_sel;
    logic        o_ready, o_stall, o_busy;
`ifdef DEMUX_DISPATCH_CNT_EN
    logic [15:0] o_cnt;
`endif

    int checks = 0;
    int errors = 0;

    demux_dispatch_ctrl #(.DATA_W(16), .SEL_W(3), .STALL_LIM(LIM)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_mode    (i_mode),
        .i_dest    (i_dest),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_in      (i_in),
        .o_data    (o_data),
        .o_sel     (o_sel),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
`ifdef DEMUX_DISPATCH_CNT_EN
        .i_cnt_sel (i_cnt_sel),
        .o_cnt     (o_cnt),
`endif
        .o_stall   (o_stall),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // reference model: one optional held word plus bookkeeping
    bit          m_held;
    logic [15:0] m_data;
    logic [2:0]  m_sel;
    int          m_blk;
    bit          m_stall;
    int          m_rr;
    int          m_cnt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_held = 0; m_data = '0; m_sel = '0; m_blk = 0; m_stall = 0; m_rr = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    endtask

    task automatic check_model();
        logic [7:0] ev;
        ev = m_held ? (8'd1 << m_sel) : 8'd0;
        chk("m_data",  32'(o_data),  32'(m_data));
        chk("m_sel",   32'(o_sel),   32'(m_sel));
        chk("m_valid", 32'(o_valid), 32'(ev));
        chk("m_busy",  32'(o_busy),  32'(m_held));
        chk("m_stall", 32'(o_stall), 32'(m_stall));
        chk("m_ready", 32'(o_ready), 32'(!m_held || i_ready[m_sel]));
`ifdef DEMUX_DISPATCH_CNT_EN
        chk("m_cnt",   32'(o_cnt),   32'(m_cnt[i_cnt_sel]));
`endif
    endtask

    task automatic step();
        bit dlv, acc;
        dlv = m_held && i_ready[m_sel];
        acc = i_valid && (!m_held || dlv);
        if (i_rst) begin
            m_reset();
        end else begin
            if (dlv) begin
                m_cnt[m_sel] = (m_cnt[m_sel] + 1) % 65536;
                m_blk = 0; m_stall = 0; m_held = 0;
            end else if (m_held) begin
                if (m_blk < 255) m_blk++;
                if (m_blk >= LIM) m_stall = 1;
            end
            if (acc) begin
                m_data = i_in;
                m_sel  = i_mode ? i_dest : 3'(m_rr);
                if (!i_mode) m_rr = (m_rr + 1) % 8;
                m_held = 1;
            end
        end
        @(posedge i_clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic rst, input logic mode, input logic [2:0] dest,
                         input logic vld, input logic [15:0] din, input logic [7:0] rdy);
        i_rst = rst; i_mode = mode; i_dest = dest; i_valid = vld; i_in = din; i_ready = rdy;
    endtask

    typedef struct {
        logic        mode;
        logic [2:0]  dest;
        logic        vld;
        logic [15:0] din;
        logic [7:0]  rdy;
        logic        exp_rdy;
        logic [7:0]  exp_valid;
        logic [15:0] exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b1, 3'd5, 1'b1, 16'hBEEF, 8'h00, 1'b1, 8'h20, 16'hBEEF, 1'b1};
        tbl[1]  = '{1'b1, 3'd5, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h20, 16'hBEEF, 1'b1};
        tbl[2]  = '{1'b1, 3'd5, 1'b0, 16'h0000, 8'hDF, 1'b0, 8'h20, 16'hBEEF, 1'b1};
        tbl[3]  = '{1'b0, 3'd1, 1'b1, 16'h1111, 8'h00, 1'b0, 8'h20, 16'hBEEF, 1'b1};
        tbl[4]  = '{1'b1, 3'd5, 1'b0, 16'h0000, 8'h20, 1'b1, 8'h00, 16'hBEEF, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 1'b1, 16'h1234, 8'hFF, 1'b1, 8'h01, 16'h1234, 1'b1};
        tbl[6]  = '{1'b0, 3'd0, 1'b1, 16'h5678, 8'h01, 1'b1, 8'h02, 16'h5678, 1'b1};
        tbl[7]  = '{1'b1, 3'd6, 1'b1, 16'h0006, 8'h02, 1'b1, 8'h40, 16'h0006, 1'b1};
        tbl[8]  = '{1'b0, 3'd7, 1'b1, 16'h0002, 8'h40, 1'b1, 8'h04, 16'h0002, 1'b1};
        tbl[9]  = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h08, 1'b0, 8'h04, 16'h0002, 1'b1};
        tbl[10] = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h04, 1'b1, 8'h00, 16'h0002, 1'b0};

        m_reset();
        i_cnt_sel = '0;
        drive(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 8'h00);
        @(posedge i_clk); #1;
        step();
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_busy",  32'(o_busy),  32'h0);
        chk("rst_stall", 32'(o_stall), 32'h0);
        chk("rst_data",  32'(o_data),  32'h0);
        chk("rst_ready", 32'(o_ready), 32'h1);

        // RR stream at full rate
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 3'd0, 1'b1, 16'(16'h1000 + i), 8'hFF);
            #1;
            chk("rr_ready", 32'(o_ready), 32'h1);
            step();
            chk("rr_sel",   32'(o_sel),   32'(i % 8));
            chk("rr_valid", 32'(o_valid), 32'(8'd1 << (i % 8)));
            chk("rr_data",  32'(o_data),  32'(16'h1000 + i));
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 8'hFF);
        step();

        // vector table: addressed hold, mode switching
        drive(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 8'h00);
        step();
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, tbl[i].mode, tbl[i].dest, tbl[i].vld, tbl[i].din, tbl[i].rdy);
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].exp_rdy));
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_data", i),  32'(o_data),  32'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_busy", i),  32'(o_busy),  32'(tbl[i].exp_busy));
        end

        // stall watchdog on lane 2 with a neighbouring lane ready
        drive(1'b0, 1'b1, 3'd2, 1'b1, 16'hA5A5, 8'h00);
        step();
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b1, 3'd2, 1'b0, 16'h0, 8'h08);
            step();
            chk($sformatf("stall_k%0d", k), 32'(o_stall), 32'(k >= LIM));
        end
        drive(1'b0, 1'b1, 3'd2, 1'b0, 16'h0, 8'h04);
        step();
        chk("stall_clear", 32'(o_stall), 32'h0);
        chk("stall_idle",  32'(o_busy),  32'h0);

        // reset while holding discards the word and the rotation
        drive(1'b0, 1'b0, 3'd0, 1'b1, 16'h7777, 8'h00);
        step();
        drive(1'b0, 1'b1, 3'd1, 1'b1, 16'h8888, 8'h00);
        step();
        drive(1'b1, 1'b1, 3'd1, 1'b1, 16'h9999, 8'hFF);
        step();
        chk("rsth_valid", 32'(o_valid), 32'h0);
        chk("rsth_busy",  32'(o_busy),  32'h0);
        chk("rsth_ready", 32'(o_ready), 32'h1);
        drive(1'b0, 1'b0, 3'd0, 1'b1, 16'h4444, 8'hFF);
        step();
        chk("rsth_rr0", 32'(o_sel), 32'h0);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 8'hFF);
        step();

`ifdef DEMUX_DISPATCH_CNT_EN
        drive(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 8'h00);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3'd4, 1'b1, 16'(i), 8'hFF);
            step();
        end
        drive(1'b0, 1'b1, 3'd7, 1'b1, 16'h77, 8'hFF);
        step();
        drive(1'b0, 1'b1, 3'd7, 1'b0, 16'h0, 8'hFF);
        step();
        i_cnt_sel = 3'd4; #1; chk("cnt_lane4", 32'(o_cnt), 32'd3);
        i_cnt_sel = 3'd7; #1; chk("cnt_lane7", 32'(o_cnt), 32'd1);
        i_cnt_sel = 3'd0; #1; chk("cnt_lane0", 32'(o_cnt), 32'd0);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [7:0] rdy;
            rdy = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            drive(($urandom_range(0, 99) == 0), 1'($urandom), 3'($urandom),
                  1'($urandom), 16'($urandom), rdy);
            i_cnt_sel = 3'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
